// File: rtl/store_drain.sv
// store_drain: drains the committed head of the store queue to memory.
// Squashed heads are discarded, misaligned committed stores raise a
// one-cycle exception pulse, aligned ones become a single write request.
// Optional drained-store counter: define STORE_DRAIN_STATS_EN.
module store_drain #(
    parameter int WIDTH_TAG  = 5,
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_DATA = 4 + WIDTH_ADDR + WIDTH_TAG
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [WIDTH_DATA-1:0] i_entry,
    input  logic                  i_empty,
    output logic                  o_re,
    input  logic [31:0]           i_data,
    input  logic [1:0]            i_size,
    input  logic                  i_data_val,
    output logic                  o_data_re,
    output logic                  o_mem_req,
    output logic [WIDTH_ADDR-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data,
    output logic [3:0]            o_mem_mask,
    input  logic                  i_mem_ack,
`ifdef STORE_DRAIN_STATS_EN
    output logic [15:0]           o_drained,
`endif
    output logic                  o_exc,
    output logic [WIDTH_TAG-1:0]  o_exc_tag
);

    // Entry field positions, LSB upwards: aval, tag, V, addr, val, A.
    localparam int AVAL_BIT = 0;
    localparam int TAG_LSB  = 1;
    localparam int V_BIT    = WIDTH_TAG + 1;
    localparam int ADDR_LSB = WIDTH_TAG + 2;
    localparam int VAL_BIT  = WIDTH_TAG + WIDTH_ADDR + 2;
    localparam int A_BIT    = WIDTH_TAG + WIDTH_ADDR + 3;

    typedef enum logic [1:0] {IDLE, REQ, POP} state_t;

    state_t                state_q, state_d;
    logic                  re_q, re_d;
    logic                  req_q, req_d;
    logic                  exc_q, exc_d;
    logic [WIDTH_TAG-1:0]  exc_tag_q, exc_tag_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [3:0]            mask_q, mask_d;

    logic                  e_a, e_val, e_v, e_aval;
    logic [WIDTH_ADDR-1:0] e_addr;
    logic [WIDTH_TAG-1:0]  e_tag;
    logic                  aligned;
    logic [3:0]            lane_mask;
    logic [31:0]           lane_data;

    assign e_a    = i_entry[A_BIT];
    assign e_val  = i_entry[VAL_BIT];
    assign e_v    = i_entry[V_BIT];
    assign e_aval = i_entry[AVAL_BIT];
    assign e_addr = i_entry[ADDR_LSB +: WIDTH_ADDR];
    assign e_tag  = i_entry[TAG_LSB +: WIDTH_TAG];

    // Alignment, byte-enable mask and lane-replicated data for the head store.
    always_comb begin
        aligned   = 1'b0;
        lane_mask = 4'b0000;
        lane_data = i_data;
        unique case (i_size)
            2'b00: begin
                aligned   = 1'b1;
                lane_mask = 4'b0001 << e_addr[1:0];
                lane_data = {4{i_data[7:0]}};
            end
            2'b01: begin
                aligned   = ~e_addr[0];
                lane_mask = 4'b0011 << e_addr[1:0];
                lane_data = {2{i_data[15:0]}};
            end
            2'b10: begin
                aligned   = (e_addr[1:0] == 2'b00);
                lane_mask = 4'b1111;
                lane_data = i_data;
            end
            default: aligned = 1'b0;
        endcase
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        exc_tag_d = exc_tag_q;
        exc_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!i_empty && e_a) begin
                    if (!e_val) begin
                        state_d = POP;
                    end else if (e_v && e_aval && i_data_val) begin
                        if (aligned) begin
                            state_d = REQ;
                            addr_d  = {e_addr[WIDTH_ADDR-1:2], 2'b00};
                            data_d  = lane_data;
                            mask_d  = lane_mask;
                        end else begin
                            state_d   = POP;
                            exc_d     = 1'b1;
                            exc_tag_d = e_tag;
                        end
                    end
                end
            end
            REQ:     if (i_mem_ack) state_d = POP;
            POP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        re_d  = (state_d == POP);
        req_d = (state_d == REQ);
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            re_q      <= 1'b0;
            req_q     <= 1'b0;
            exc_q     <= 1'b0;
            exc_tag_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            re_q      <= re_d;
            req_q     <= req_d;
            exc_q     <= exc_d;
            exc_tag_q <= exc_tag_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
        end
    end

`ifdef STORE_DRAIN_STATS_EN
    logic [15:0] drained_q;
    // Count stores that memory accepted; wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                         drained_q <= '0;
        else if (state_q == REQ && i_mem_ack) drained_q <= drained_q + 16'd1;
    end
    assign o_drained = drained_q;
`endif

    assign o_re       = re_q;
    assign o_data_re  = re_q;
    assign o_mem_req  = req_q;
    assign o_mem_addr = addr_q;
    assign o_mem_data = data_q;
    assign o_mem_mask = mask_q;
    assign o_exc      = exc_q;
    assign o_exc_tag  = exc_tag_q;

endmodule

// File: tb/tb_store_drain.sv
// Directed bench for store_drain: drain, lanes, squash, exception, reset.
module tb_store_drain;
    localparam int WT = 5;
    localparam int WA = 32;
    localparam int WD = 4 + WA + WT;

    logic          clk, rst_n;
    logic [WD-1:0] entry;
    logic          empty, re, data_val, data_re, mem_req, mem_ack, exc;
    logic [31:0]   data, mem_data;
    logic [1:0]    size;
    logic [WA-1:0] mem_addr;
    logic [3:0]    mem_mask;
    logic [WT-1:0] exc_tag;
`ifdef STORE_DRAIN_STATS_EN
    logic [15:0]   drained;
`endif

    int n_chk = 0;
    int n_fail = 0;

    store_drain dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_entry(entry), .i_empty(empty), .o_re(re),
        .i_data(data), .i_size(size), .i_data_val(data_val), .o_data_re(data_re),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
        .o_mem_mask(mem_mask), .i_mem_ack(mem_ack),
`ifdef STORE_DRAIN_STATS_EN
        .o_drained(drained),
`endif
        .o_exc(exc), .o_exc_tag(exc_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WD-1:0] mk(input logic a, input logic v_l, input logic [WA-1:0] ad,
                                         input logic v, input logic [WT-1:0] t, input logic av);
        return {a, v_l, ad, v, t, av};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; empty = 1'b1; entry = '0; data = '0; size = 2'b00;
        data_val = 1'b0; mem_ack = 1'b0;
        #12;
        n_chk++;
        if ({re, data_re, mem_req, exc, mem_mask, mem_addr, mem_data, exc_tag} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got re=%b dre=%b req=%b exc=%b mask=%h addr=%h data=%h tag=%h, want all 0",
                     re, data_re, mem_req, exc, mem_mask, mem_addr, mem_data, exc_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word();
        entry = mk(1, 1, 32'h100, 1, 5'd2, 1); empty = 0;
        data = 32'hDEADBEEF; size = 2'b10; data_val = 1;
        tick();
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_mask !== 4'hF || mem_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_req: req=%b addr=%h mask=%h data=%h, want 1 100 f deadbeef",
                     mem_req, mem_addr, mem_mask, mem_data);
        end
        // Head changes while waiting must not disturb the latched bus.
        entry = mk(1, 1, 32'h300, 1, 5'd9, 1); data = 32'h11111111;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_mask !== 4'hF || mem_data !== 32'hDEADBEEF || re !== 1'b0) begin
                n_fail++;
                $display("FAIL word_hold%0d: req=%b addr=%h mask=%h data=%h re=%b, want 1 100 f deadbeef 0",
                         i, mem_req, mem_addr, mem_mask, mem_data, re);
            end
        end
        mem_ack = 1;
        tick();
        mem_ack = 0; empty = 1;
        n_chk++;
        if (re !== 1'b1 || data_re !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL word_pop: re=%b dre=%b req=%b, want 1 1 0", re, data_re, mem_req);
        end
        tick();
        n_chk++;
        if (re !== 1'b0 || data_re !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL word_idle: re=%b dre=%b req=%b, want 0 0 0", re, data_re, mem_req);
        end
    endtask

    task automatic test_lanes();
        logic [WA-1:0] addrs [2] = '{32'h203, 32'h102};
        logic [31:0]   dins  [2] = '{32'hFFFFFF5A, 32'hABCD1234};
        logic [1:0]    szs   [2] = '{2'b00, 2'b01};
        logic [WA-1:0] eaddr [2] = '{32'h200, 32'h100};
        logic [3:0]    emask [2] = '{4'b1000, 4'b1100};
        logic [31:0]   edata [2] = '{32'h5A5A5A5A, 32'h12341234};
        for (int i = 0; i < 2; i++) begin
            entry = mk(1, 1, addrs[i], 1, 5'd1, 1); empty = 0;
            data = dins[i]; size = szs[i]; data_val = 1;
            tick();
            // Ack in the same cycle the request rises.
            mem_ack = 1;
            n_chk++;
            if (mem_req !== 1'b1 || mem_addr !== eaddr[i] || mem_mask !== emask[i] || mem_data !== edata[i]) begin
                n_fail++;
                $display("FAIL lanes%0d: req=%b addr=%h mask=%b data=%h, want 1 %h %b %h",
                         i, mem_req, mem_addr, mem_mask, mem_data, eaddr[i], emask[i], edata[i]);
            end
            tick();
            mem_ack = 0; empty = 1;
            n_chk++;
            if (re !== 1'b1 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL lanes_pop%0d: re=%b req=%b, want 1 0", i, re, mem_req);
            end
            tick();
        end
    endtask

    task automatic test_squash();
        entry = mk(1, 0, 32'h400, 1, 5'd4, 1); empty = 0; data_val = 0;
        tick();
        empty = 1;
        n_chk++;
        if (re !== 1'b1 || data_re !== 1'b1 || mem_req !== 1'b0 || exc !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_pop: re=%b dre=%b req=%b exc=%b, want 1 1 0 0", re, data_re, mem_req, exc);
        end
        tick();
        n_chk++;
        if (re !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_idle: re=%b req=%b, want 0 0", re, mem_req);
        end
    endtask

    task automatic test_misaligned();
        logic [WA-1:0] addrs [2] = '{32'h101, 32'h104};
        logic [1:0]    szs   [2] = '{2'b01, 2'b11};
        logic [WT-1:0] tags  [2] = '{5'd7, 5'd3};
        for (int i = 0; i < 2; i++) begin
            entry = mk(1, 1, addrs[i], 1, tags[i], 1); empty = 0;
            size = szs[i]; data_val = 1;
            tick();
            empty = 1;
            n_chk++;
            if (exc !== 1'b1 || exc_tag !== tags[i] || re !== 1'b1 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign%0d: exc=%b tag=%0d re=%b req=%b, want 1 %0d 1 0",
                         i, exc, exc_tag, re, mem_req, tags[i]);
            end
            tick();
            n_chk++;
            if (exc !== 1'b0 || re !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_end%0d: exc=%b re=%b req=%b, want 0 0 0", i, exc, re, mem_req);
            end
        end
    endtask

    task automatic test_stats();
`ifdef STORE_DRAIN_STATS_EN
        n_chk++;
        if (drained !== 16'd3) begin
            n_fail++;
            $display("FAIL drained_count: got %0d, want 3", drained);
        end
`endif
    endtask

    task automatic test_aval_reset();
        int bad = 0;
        entry = mk(1, 1, 32'h500, 1, 5'd6, 0); empty = 0;
        data = 32'h01020304; size = 2'b10; data_val = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req !== 1'b0 || re !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL aval_wait: %0d early activity cycles, want 0", bad);
        end
        entry = mk(1, 1, 32'h500, 1, 5'd6, 1);
        tick();
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            n_fail++;
            $display("FAIL aval_req: req=%b addr=%h, want 1 500", mem_req, mem_addr);
        end
        #2;
        rst_n = 0; empty = 1;
        #1;
        n_chk++;
        if (mem_req !== 1'b0 || mem_mask !== 4'h0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_req: req=%b mask=%h addr=%h, want 0 0 0", mem_req, mem_mask, mem_addr);
        end
        @(negedge clk);
        rst_n = 1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (re !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_pop_after_reset: %0d active cycles, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_squash();
        test_misaligned();
        test_stats();
        test_aval_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
